regfile_ctrl_seq: RTL and testbench
===================================

Name: regfile_ctrl_seq

Overview:
- Instruction-sequencing controller that drives the register-file/ALU datapath's control inputs.
- Controls driven: one-hot register write enables, A/B read selects, 8-bit ALU opcode and immediate select.
- Accepts 16-bit instruction words over a valid/ready handshake, decodes them and steps each through a fixed DECODE/EXECUTE/WRITEBACK sequence.
- Sits between an instruction source (switch bank, ROM walker or testbench) and the datapath, replacing hard-coded control.

Parameters:
- NUM_REGS, 16, number of architectural registers; width of reg_en. Fixed at 16 for this revision.
- OP_W, 8, ALU opcode width.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- instr  in  16  instruction word: [15:8] ALU opcode, [7:4] Rdest, [3:0] Rsrc or 4-bit immediate
- instr_valid  in  1  instr is valid this cycle
- instr_ready  out  1  controller can accept an instruction
- reg_en  out  16  one-hot register write enable
- reg_a_sel  out  4  read mux A select (Rdest)
- reg_b_sel  out  4  read mux B select (Rsrc)
- imm  out  4  immediate value for the ALU B-input mux
- imm_sel  out  1  B operand is the immediate
- alu_op  out  8  ALU opcode
- flags_en  out  1  flag register write enable
- illegal_op  out  1  one-cycle pulse when an undefined opcode is retired
- busy  out  1  controller not in IDLE

Behaviour:
- Clock and reset: single clock domain. Reset is synchronous and active-high.
- Reset values:
  - reg_en=0, flags_en=0, illegal_op=0, busy=0.
  - reg_a_sel=0, reg_b_sel=0, imm=0, imm_sel=0.
  - alu_op=8'h17 (NOP).
  - instr_ready=0 while reset is high.
- FSM states: IDLE, DECODE, EXECUTE, WRITEBACK. All outputs are registered.
- IDLE:
  - instr_ready=1, busy=0, alu_op=NOP.
  - On instr_valid && instr_ready (cycle T), capture instr and go to DECODE.
- DECODE (T+1):
  - Drive alu_op=instr[15:8], reg_a_sel=instr[7:4], reg_b_sel=instr[3:0], imm=instr[3:0].
  - Drive imm_sel=1 for opcodes 01,03,06,07,09,0B,12,14 (hex).
  - instr_ready=0, busy=1.
- EXECUTE (T+2): all selects and alu_op held so the datapath settles; no enables asserted.
- WRITEBACK (T+3), selects held:
  - Legal ops other than CMP/CMPI/CMPU/NOP: reg_en = 1<<Rdest and flags_en=1, for exactly one cycle.
  - CMP (0A), CMPI (0B), CMPU (0C): flags_en=1, reg_en=0.
  - NOP (17): both enables 0.
  - Opcode > 8'h17: both enables 0, illegal_op=1 for this cycle.
- Return to IDLE at T+4: alu_op back to NOP, instr_ready=1.
- Throughput: one instruction per 4 cycles; minimum accept spacing is 4 cycles.
- Handshake:
  - instr is sampled only on the accept cycle; later changes to instr or instr_valid are ignored.
  - instr_valid held high continuously issues back-to-back at 4-cycle spacing.
- Invariants:
  - reg_en is at most one-hot in every cycle.
  - reg_en and flags_en are never high outside WRITEBACK.
- Reset in any state: next cycle is IDLE with all reset values. No enable is asserted in the cycle following reset, even if reset hit during WRITEBACK.

Optional Feature:
- Macro: REGFILE_CTRL_RETIRE_CNT_EN.
- When defined:
  - Adds output retire_cnt (16 bits), reset to 0.
  - Increments by 1 on each WRITEBACK cycle with a legal opcode, NOP included, illegal excluded.
  - Wraps from FFFF to 0000.
- When undefined: the port and the counter logic are absent; all other behaviour is unchanged.

Decomposition:
- Shared package regfile_ctrl_pkg holds:
  - opcode localparams ADD..NOP (00..17);
  - the immediate-opcode list;
  - state encoding constants;
  - the NOP default opcode.
- One natural sub-module, regfile_instr_decode (combinational). Maps opcode to {legal, writes_rd, writes_flags, uses_imm}. The FSM registers its outputs.

Test Plan:
- Reset then instr=16'h0031 (ADD Rdest=3, Rsrc=1), valid for 1 cycle -> T+1: alu_op=00, a_sel=3, b_sel=1, imm_sel=0; T+3: reg_en=16'h0008, flags_en=1; T+4: instr_ready=1, alu_op=17.
- instr=16'h0125 (ADDI R2,#5) -> imm_sel=1, imm=5; T+3: reg_en=16'h0004.
- instr=16'h0A47 (CMP R4,R7) -> T+3: flags_en=1, reg_en=0. Then instr=16'h1700 (NOP) -> no enables.
- instr=16'h2010 (illegal) -> T+3: illegal_op=1 for one cycle, reg_en=0, flags_en=0.
- instr_valid held high with 4 distinct ADDs -> accepts at T, T+4, T+8, T+12; reg_en pulses one-hot at T+3, T+7, T+11, T+15; reg_en never multi-hot.
- Reset asserted during WRITEBACK of ADD R9 -> next cycle reg_en=0, IDLE, instr_ready=1 after reset deasserts. With REGFILE_CTRL_RETIRE_CNT_EN: 3 legal, 1 illegal -> retire_cnt=3.

Source files
------------

// File: rtl/regfile_ctrl_pkg.sv
// Shared opcode map, state encoding and decode record for the register-file
// sequencing controller.
package regfile_ctrl_pkg;

  localparam int NUM_REGS = 16;
  localparam int OP_W     = 8;

  localparam logic [OP_W-1:0] OP_ADD  = 8'h00;
  localparam logic [OP_W-1:0] OP_ADDI = 8'h01;
  localparam logic [OP_W-1:0] OP_SUB  = 8'h02;
  localparam logic [OP_W-1:0] OP_SUBI = 8'h03;
  localparam logic [OP_W-1:0] OP_AND  = 8'h04;
  localparam logic [OP_W-1:0] OP_OR   = 8'h05;
  localparam logic [OP_W-1:0] OP_ANDI = 8'h06;
  localparam logic [OP_W-1:0] OP_ORI  = 8'h07;
  localparam logic [OP_W-1:0] OP_XOR  = 8'h08;
  localparam logic [OP_W-1:0] OP_XORI = 8'h09;
  localparam logic [OP_W-1:0] OP_CMP  = 8'h0A;
  localparam logic [OP_W-1:0] OP_CMPI = 8'h0B;
  localparam logic [OP_W-1:0] OP_CMPU = 8'h0C;
  localparam logic [OP_W-1:0] OP_MOV  = 8'h0D;
  localparam logic [OP_W-1:0] OP_NOT  = 8'h0E;
  localparam logic [OP_W-1:0] OP_LSH  = 8'h0F;
  localparam logic [OP_W-1:0] OP_RSH  = 8'h10;
  localparam logic [OP_W-1:0] OP_ASH  = 8'h11;
  localparam logic [OP_W-1:0] OP_LSHI = 8'h12;
  localparam logic [OP_W-1:0] OP_ROT  = 8'h13;
  localparam logic [OP_W-1:0] OP_ROTI = 8'h14;
  localparam logic [OP_W-1:0] OP_MUL  = 8'h15;
  localparam logic [OP_W-1:0] OP_PASS = 8'h16;
  localparam logic [OP_W-1:0] OP_NOP  = 8'h17;

  // Highest defined opcode; anything above retires as illegal.
  localparam logic [OP_W-1:0] OP_LAST = OP_NOP;
  localparam logic [OP_W-1:0] OP_DEFAULT = OP_NOP;

  localparam int NUM_IMM_OPS = 8;
  localparam logic [OP_W-1:0] IMM_OPS [NUM_IMM_OPS] = '{
    OP_ADDI, OP_SUBI, OP_ANDI, OP_ORI, OP_XORI, OP_CMPI, OP_LSHI, OP_ROTI
  };

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_DECODE    = 2'd1,
    S_EXECUTE   = 2'd2,
    S_WRITEBACK = 2'd3
  } state_t;

  typedef struct packed {
    logic legal;
    logic writes_rd;
    logic writes_flags;
    logic uses_imm;
  } dec_t;

  function automatic logic is_imm_op(input logic [OP_W-1:0] op);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < NUM_IMM_OPS; i++) begin
      if (op == IMM_OPS[i]) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/regfile_ctrl_seq_if.sv
// Instruction handshake and datapath control bundle. master is the instruction
// source, slave is the sequencing controller.
interface regfile_ctrl_seq_if;
  import regfile_ctrl_pkg::*;

  // valid/ready: a word transfers on a cycle where instr_valid and instr_ready
  // are both high at the clock edge; instr is only looked at on that cycle.
  logic [15:0]         instr;
  logic                instr_valid;
  logic                instr_ready;
  logic [NUM_REGS-1:0] reg_en;
  logic [3:0]          reg_a_sel;
  logic [3:0]          reg_b_sel;
  logic [3:0]          imm;
  logic                imm_sel;
  logic [OP_W-1:0]     alu_op;
  logic                flags_en;
  logic                illegal_op;
  logic                busy;

  modport master (
    output instr, instr_valid,
    input  instr_ready, reg_en, reg_a_sel, reg_b_sel, imm, imm_sel,
           alu_op, flags_en, illegal_op, busy
  );

  modport slave (
    input  instr, instr_valid,
    output instr_ready, reg_en, reg_a_sel, reg_b_sel, imm, imm_sel,
           alu_op, flags_en, illegal_op, busy
  );

endinterface

// File: rtl/regfile_instr_decode.sv
// Combinational opcode classifier: legality, register write, flag write and
// immediate-operand use.
module regfile_instr_decode
  import regfile_ctrl_pkg::*;
(
  input  logic [OP_W-1:0] opcode,
  output dec_t            dec
);

  always_comb begin
    dec.legal        = (opcode <= OP_LAST);
    dec.uses_imm     = dec.legal && is_imm_op(opcode);
    dec.writes_flags = dec.legal && (opcode != OP_NOP);
    // Compares only update flags; NOP touches nothing.
    dec.writes_rd    = dec.writes_flags &&
                       (opcode != OP_CMP) && (opcode != OP_CMPI) && (opcode != OP_CMPU);
  end

endmodule

// File: rtl/regfile_ctrl_seq.sv
// Sequencing controller: accepts one instruction, then walks it through
// DECODE/EXECUTE/WRITEBACK with registered control outputs.
// Optional retire counter: define REGFILE_CTRL_RETIRE_CNT_EN.
module regfile_ctrl_seq
  import regfile_ctrl_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  regfile_ctrl_seq_if.slave bus,
  output state_t       state_dbg
`ifdef REGFILE_CTRL_RETIRE_CNT_EN
  , output logic [15:0] retire_cnt
`endif
);

  state_t              state_q, state_d;
  logic [15:0]         instr_q;
  logic [15:0]         word;
  logic                accept;
  dec_t                dec;

  logic                ready_q, ready_d;
  logic                busy_q, busy_d;
  logic [NUM_REGS-1:0] reg_en_q, reg_en_d;
  logic [3:0]          a_sel_q, a_sel_d;
  logic [3:0]          b_sel_q, b_sel_d;
  logic [3:0]          imm_q, imm_d;
  logic                imm_sel_q, imm_sel_d;
  logic [OP_W-1:0]     alu_op_q, alu_op_d;
  logic                flags_en_q, flags_en_d;
  logic                illegal_q, illegal_d;

  assign accept = (state_q == S_IDLE) && ready_q && bus.instr_valid;
  // On the accept edge the outputs for DECODE come straight from the bus word.
  assign word   = accept ? bus.instr : instr_q;

  regfile_instr_decode u_decode (
    .opcode (word[15:8]),
    .dec    (dec)
  );

  always_comb begin
    state_d    = state_q;
    ready_d    = 1'b0;
    busy_d     = 1'b1;
    alu_op_d   = word[15:8];
    a_sel_d    = word[7:4];
    b_sel_d    = word[3:0];
    imm_d      = word[3:0];
    imm_sel_d  = dec.uses_imm;
    reg_en_d   = '0;
    flags_en_d = 1'b0;
    illegal_d  = 1'b0;

    case (state_q)
      S_IDLE:      if (accept) state_d = S_DECODE;
      S_DECODE:    state_d = S_EXECUTE;
      S_EXECUTE:   state_d = S_WRITEBACK;
      S_WRITEBACK: state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase

    if (state_d == S_IDLE) begin
      ready_d   = 1'b1;
      busy_d    = 1'b0;
      alu_op_d  = OP_DEFAULT;
      a_sel_d   = '0;
      b_sel_d   = '0;
      imm_d     = '0;
      imm_sel_d = 1'b0;
    end

    if (state_d == S_WRITEBACK) begin
      reg_en_d   = dec.writes_rd ? (NUM_REGS'(1) << word[7:4]) : '0;
      flags_en_d = dec.writes_flags;
      illegal_d  = !dec.legal;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      instr_q    <= '0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      alu_op_q   <= OP_DEFAULT;
      a_sel_q    <= '0;
      b_sel_q    <= '0;
      imm_q      <= '0;
      imm_sel_q  <= 1'b0;
      reg_en_q   <= '0;
      flags_en_q <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      if (accept) instr_q <= bus.instr;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      alu_op_q   <= alu_op_d;
      a_sel_q    <= a_sel_d;
      b_sel_q    <= b_sel_d;
      imm_q      <= imm_d;
      imm_sel_q  <= imm_sel_d;
      reg_en_q   <= reg_en_d;
      flags_en_q <= flags_en_d;
      illegal_q  <= illegal_d;
    end
  end

`ifdef REGFILE_CTRL_RETIRE_CNT_EN
  logic [15:0] retire_q;

  // Counts at the end of each legal WRITEBACK cycle; wraps naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      retire_q <= '0;
    end else if (state_q == S_WRITEBACK && dec.legal) begin
      retire_q <= retire_q + 16'd1;
    end
  end

  assign retire_cnt = retire_q;
`endif

  assign bus.instr_ready = ready_q;
  assign bus.busy        = busy_q;
  assign bus.alu_op      = alu_op_q;
  assign bus.reg_a_sel   = a_sel_q;
  assign bus.reg_b_sel   = b_sel_q;
  assign bus.imm         = imm_q;
  assign bus.imm_sel     = imm_sel_q;
  assign bus.reg_en      = reg_en_q;
  assign bus.flags_en    = flags_en_q;
  assign bus.illegal_op  = illegal_q;
  assign state_dbg       = state_q;

endmodule

// File: tb/tb_regfile_ctrl_seq.sv
// Directed bench for regfile_ctrl_seq; retire counter checks are built when
// REGFILE_CTRL_RETIRE_CNT_EN is defined.
module tb_regfile_ctrl_seq;
  import regfile_ctrl_pkg::*;

  logic   clk;
  logic   reset;
  state_t state_dbg;
  int     total;
  int     bad;

  regfile_ctrl_seq_if bus ();

`ifdef REGFILE_CTRL_RETIRE_CNT_EN
  logic [15:0] retire_cnt;
`endif

  regfile_ctrl_seq dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .state_dbg  (state_dbg)
`ifdef REGFILE_CTRL_RETIRE_CNT_EN
    , .retire_cnt (retire_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: run did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Issues one word from IDLE and checks every phase through the return to IDLE.
  task automatic issue(input logic [15:0] w, input logic [7:0] e_op, input logic [3:0] e_a,
                       input logic [3:0] e_b, input logic e_isel, input logic [15:0] e_en,
                       input logic e_fl, input logic e_ill);
    check("pre_ready", 32'(bus.instr_ready), 32'd1);
    bus.instr       = w;
    bus.instr_valid = 1'b1;
    step();
    bus.instr_valid = 1'b0;
    bus.instr       = ~w;
    check("dec_state", 32'(state_dbg), 32'(S_DECODE));
    check("dec_op", 32'(bus.alu_op), 32'(e_op));
    check("dec_a", 32'(bus.reg_a_sel), 32'(e_a));
    check("dec_b", 32'(bus.reg_b_sel), 32'(e_b));
    check("dec_imm", 32'(bus.imm), 32'(e_b));
    check("dec_isel", 32'(bus.imm_sel), 32'(e_isel));
    check("dec_ready", 32'(bus.instr_ready), 32'd0);
    check("dec_busy", 32'(bus.busy), 32'd1);
    check("dec_en", 32'({bus.reg_en, bus.flags_en}), 32'd0);
    step();
    check("exe_op", 32'(bus.alu_op), 32'(e_op));
    check("exe_en", 32'({bus.reg_en, bus.flags_en, bus.illegal_op}), 32'd0);
    step();
    check("wb_state", 32'(state_dbg), 32'(S_WRITEBACK));
    check("wb_a", 32'(bus.reg_a_sel), 32'(e_a));
    check("wb_reg_en", 32'(bus.reg_en), 32'(e_en));
    check("wb_flags", 32'(bus.flags_en), 32'(e_fl));
    check("wb_ill", 32'(bus.illegal_op), 32'(e_ill));
    step();
    check("idle_ready", 32'(bus.instr_ready), 32'd1);
    check("idle_op", 32'(bus.alu_op), 32'h17);
    check("idle_busy", 32'(bus.busy), 32'd0);
    check("idle_en", 32'({bus.reg_en, bus.flags_en, bus.illegal_op}), 32'd0);
  endtask

  logic [3:0]  b2b_rd  [4] = '{4'd5, 4'd0, 4'd15, 4'd10};
  logic [15:0] b2b_exp [4] = '{16'h0020, 16'h0001, 16'h8000, 16'h0400};

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    bus.instr       = '0;
    bus.instr_valid = 1'b0;
    step();
    step();
    check("rst_reg_en", 32'(bus.reg_en), 32'd0);
    check("rst_flags", 32'(bus.flags_en), 32'd0);
    check("rst_ill", 32'(bus.illegal_op), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_sels", 32'({bus.reg_a_sel, bus.reg_b_sel, bus.imm, bus.imm_sel}), 32'd0);
    check("rst_op", 32'(bus.alu_op), 32'h17);
    check("rst_ready", 32'(bus.instr_ready), 32'd0);
    reset = 1'b0;
    step();
    check("post_rst_state", 32'(state_dbg), 32'(S_IDLE));

    issue(16'h0031, 8'h00, 4'd3, 4'd1, 1'b0, 16'h0008, 1'b1, 1'b0);
    issue(16'h0125, 8'h01, 4'd2, 4'd5, 1'b1, 16'h0004, 1'b1, 1'b0);
    issue(16'h0A47, 8'h0A, 4'd4, 4'd7, 1'b0, 16'h0000, 1'b1, 1'b0);
    issue(16'h1700, 8'h17, 4'd0, 4'd0, 1'b0, 16'h0000, 1'b0, 1'b0);
    issue(16'h2010, 8'h20, 4'd1, 4'd0, 1'b0, 16'h0000, 1'b0, 1'b1);
    check("ill_pulse_gone", 32'(bus.illegal_op), 32'd0);
    issue(16'h1294, 8'h12, 4'd9, 4'd4, 1'b1, 16'h0200, 1'b1, 1'b0);

    // valid held high: accepts every 4 cycles
    bus.instr_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.instr = {8'h00, b2b_rd[i], 4'h1};
      step();
      check("b2b_dec_busy", 32'({bus.busy, bus.instr_ready}), 32'b10);
      check("b2b_onehot", 32'($onehot0(bus.reg_en)), 32'd1);
      step();
      check("b2b_exe_en", 32'(bus.reg_en), 32'd0);
      step();
      check("b2b_wb_en", 32'(bus.reg_en), 32'(b2b_exp[i]));
      check("b2b_onehot", 32'($onehot0(bus.reg_en)), 32'd1);
      step();
      check("b2b_idle_ready", 32'(bus.instr_ready), 32'd1);
      check("b2b_idle_en", 32'(bus.reg_en), 32'd0);
    end
    bus.instr_valid = 1'b0;

    // reset landing in WRITEBACK of ADD R9
    bus.instr       = 16'h0092;
    bus.instr_valid = 1'b1;
    step();
    bus.instr_valid = 1'b0;
    step();
    step();
    check("rwb_reg_en", 32'(bus.reg_en), 32'h0200);
    reset = 1'b1;
    step();
    check("rwb_after_en", 32'({bus.reg_en, bus.flags_en}), 32'd0);
    check("rwb_after_state", 32'(state_dbg), 32'(S_IDLE));
    check("rwb_after_ready", 32'(bus.instr_ready), 32'd0);
    reset = 1'b0;
    step();
    check("rwb_ready", 32'(bus.instr_ready), 32'd1);

`ifdef REGFILE_CTRL_RETIRE_CNT_EN
    check("cnt_reset", 32'(retire_cnt), 32'd0);
    issue(16'h0031, 8'h00, 4'd3, 4'd1, 1'b0, 16'h0008, 1'b1, 1'b0);
    check("cnt_one", 32'(retire_cnt), 32'd1);
    issue(16'h2010, 8'h20, 4'd1, 4'd0, 1'b0, 16'h0000, 1'b0, 1'b1);
    check("cnt_ill", 32'(retire_cnt), 32'd1);
    issue(16'h1700, 8'h17, 4'd0, 4'd0, 1'b0, 16'h0000, 1'b0, 1'b0);
    issue(16'h0A47, 8'h0A, 4'd4, 4'd7, 1'b0, 16'h0000, 1'b1, 1'b0);
    check("cnt_three", 32'(retire_cnt), 32'd3);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
